// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined RV32 immediate generator with valid/ready handshake and
//            a 2-entry (output + skid) buffer. Build option: IMM_GEN_ZIMM_EN
//            enables CSR zimm (Z-type) decode for CSRRWI/CSRRSI/CSRRCI.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    localparam logic [2:0] c_type_none = 3'd0;
    localparam logic [2:0] c_type_i    = 3'd1;
    localparam logic [2:0] c_type_s    = 3'd2;
    localparam logic [2:0] c_type_b    = 3'd3;
    localparam logic [2:0] c_type_u    = 3'd4;
    localparam logic [2:0] c_type_j    = 3'd5;
`ifdef IMM_GEN_ZIMM_EN
    localparam logic [2:0] c_type_z    = 3'd6;
`endif

    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_type;
    logic            w_illegal;
    logic            w_in_fire;
    logic            w_out_fire;

    logic            r_in_ready;
    logic            r_out_valid;
    logic [XLEN-1:0] r_immediate;
    logic [2:0]      r_imm_type;
    logic            r_illegal;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_type;
    logic            r_skid_illegal;

    // Every format is built as a 32-bit value sign-extended from instr[31]
    always_comb begin
        w_imm32   = '0;
        w_type    = c_type_none;
        w_illegal = 1'b0;
        case (instruction[6:0])
            c_op_load, c_op_opimm, c_op_jalr: begin
                w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
                w_type  = c_type_i;
            end
            c_op_system: begin
`ifdef IMM_GEN_ZIMM_EN
                if (instruction[14]) begin
                    w_imm32 = {27'd0, instruction[19:15]};
                    w_type  = c_type_z;
                end else begin
                    w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
                    w_type  = c_type_i;
                end
`else
                w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
                w_type  = c_type_i;
`endif
            end
            c_op_store: begin
                w_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                w_type  = c_type_s;
            end
            c_op_branch: begin
                w_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                           instruction[30:25], instruction[11:8], 1'b0};
                w_type  = c_type_b;
            end
            c_op_lui, c_op_auipc: begin
                w_imm32 = {instruction[31:12], 12'd0};
                w_type  = c_type_u;
            end
            c_op_jal: begin
                w_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                           instruction[20], instruction[30:21], 1'b0};
                w_type  = c_type_j;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 32) begin : g_xlen32
            assign w_imm = w_imm32;
        end else begin : g_xlen_wide
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end
    endgenerate

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // The skid entry only fills while the output holds, so it is always the
    // younger entry and in_ready is simply "skid empty" one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_immediate    <= '0;
            r_imm_type     <= c_type_none;
            r_illegal      <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_type    <= c_type_none;
            r_skid_illegal <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_fire || !r_out_valid) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_immediate  <= r_skid_imm;
                r_imm_type   <= r_skid_type;
                r_illegal    <= r_skid_illegal;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_immediate <= w_imm;
                r_imm_type  <= w_type;
                r_illegal   <= w_illegal;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_valid   <= 1'b1;
            r_skid_imm     <= w_imm;
            r_skid_type    <= w_type;
            r_skid_illegal <= w_illegal;
            r_in_ready     <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign immediate = r_immediate;
    assign imm_type  = r_imm_type;
    assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Directed self-checking bench for imm_gen_pipe (XLEN=32).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] immediate;
    logic [2:0]      imm_type;
    logic            illegal;

    int checks;
    int errors;

    imm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .immediate   (immediate),
        .imm_type    (imm_type),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (immediate !== 32'h0) begin errors++; $display("FAIL reset_immediate: got %h expected 00000000", immediate); end
        checks++; if (imm_type !== 3'd0) begin errors++; $display("FAIL reset_imm_type: got %0d expected 0", imm_type); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        out_ready = 1'b1; in_valid = 1'b1; instruction = 32'hFFF00093;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b expected 1", out_valid); end
        checks++; if (immediate !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm: got %h expected ffffffff", immediate); end
        checks++; if (imm_type !== 3'd1) begin errors++; $display("FAIL addi_type: got %0d expected 1", imm_type); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal: got %b expected 0", illegal); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [3];
        logic [31:0] exp_imm [3];
        logic [2:0]  exp_type [3];
        // BEQ x0,x0,-4 ; JAL x0,+0xFFFFE ; LUI x1,0x80000
        instrs[0] = 32'hFE000EE3; exp_imm[0] = 32'hFFFFFFFC; exp_type[0] = 3'd3;
        instrs[1] = 32'h7FFFF06F; exp_imm[1] = 32'h000FFFFE; exp_type[1] = 3'd5;
        instrs[2] = 32'h800000B7; exp_imm[2] = 32'h80000000; exp_type[2] = 3'd4;
        out_ready = 1'b1;
        in_valid = 1'b1; instruction = instrs[0];
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k < 2) instruction = instrs[k+1];
            else in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d: got valid=%b ready=%b expected 1/1", k, out_valid, in_ready); end
            checks++; if (immediate !== exp_imm[k]) begin errors++; $display("FAIL b2b_imm_%0d: got %h expected %h", k, immediate, exp_imm[k]); end
            checks++; if (imm_type !== exp_type[k]) begin errors++; $display("FAIL b2b_type_%0d: got %0d expected %0d", k, imm_type, exp_type[k]); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = 32'hFE112E23;  // SW, offset -4
        tick();
        instruction = 32'h00812083;                   // LW, offset 8
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_first: got valid=%b ready=%b expected 1/1", out_valid, in_ready); end
        tick();
        instruction = 32'hFFF00093;                   // must not be captured
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        checks++; if (immediate !== 32'hFFFFFFFC || imm_type !== 3'd2) begin errors++; $display("FAIL stall_hold_sw: got %h/%0d expected fffffffc/2", immediate, imm_type); end
        tick();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || immediate !== 32'hFFFFFFFC) begin errors++; $display("FAIL stall_stable: got valid=%b ready=%b imm=%h expected 1/0/fffffffc", out_valid, in_ready, immediate); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || immediate !== 32'h00000008 || imm_type !== 3'd1) begin errors++; $display("FAIL stall_release_lw: got valid=%b imm=%h type=%0d expected 1/00000008/1", out_valid, immediate, imm_type); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %b expected 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h0000007F;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got valid=%b illegal=%b expected 1/1", out_valid, illegal); end
        checks++; if (immediate !== 32'h0 || imm_type !== 3'd0) begin errors++; $display("FAIL illegal_imm: got %h/%0d expected 00000000/0", immediate, imm_type); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; instruction = 32'hFFF00093;
        tick();
        instruction = 32'h00812083;
        tick();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_full: got valid=%b ready=%b expected 1/0", out_valid, in_ready); end
        flush = 1'b1; in_valid = 1'b0;
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        // flush wins over a simultaneous accept
        in_valid = 1'b1; flush = 1'b1; instruction = 32'h800000B7;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_priority: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_zimm();
        logic [31:0] exp_imm;
        logic [2:0]  exp_type;
`ifdef IMM_GEN_ZIMM_EN
        exp_imm = 32'h00000003; exp_type = 3'd6;
`else
        exp_imm = 32'h00000340; exp_type = 3'd1;
`endif
        out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h3401D073;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || immediate !== exp_imm || imm_type !== exp_type) begin errors++; $display("FAIL csrrwi: got valid=%b imm=%h type=%0d expected 1/%h/%0d", out_valid, immediate, imm_type, exp_imm, exp_type); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; instruction = 32'hFFF00093;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_loaded: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || immediate !== 32'h0) begin errors++; $display("FAIL areset_immediate: got valid=%b ready=%b imm=%h expected 0/1/00000000", out_valid, in_ready, immediate); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_flush();
        test_zimm();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
